alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one combinational ALU (and/or/add/sub datapath, 32-bit, r1 = r2 op r3) between two requesters.
- Round-robin arbitration, valid/ready request and response handshakes, operands and opcode registered toward the ALU.
- The ALU result is captured after a fixed settle delay and returned to the requester that was granted.
- Sits between the decode/issue logic and the shared ALU instance.

Parameters:
- WIDTH, 32, operand/result width in bits
- OPW, 3, opcode width
- SETTLE, 1, cycles the ALU inputs are held before the result is sampled (legal range 1..15)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  2  bit i: requester i presents an operation
- req_ready  out  2  bit i: arbiter accepts requester i this cycle
- req_op  in  2*OPW  opcode; requester i in slice [i*OPW +: OPW]
- req_a  in  2*WIDTH  operand r2, per-requester slice
- req_b  in  2*WIDTH  operand r3, per-requester slice
- rsp_valid  out  2  bit i: result for requester i is valid
- rsp_ready  in  2  bit i: requester i takes its result
- rsp_data  out  WIDTH  result r1, shared bus; meaningful only where rsp_valid is set
- alu_op  out  OPW  to the shared ALU
- alu_a  out  WIDTH  to ALU operand r2
- alu_b  out  WIDTH  to ALU operand r3
- alu_y  in  WIDTH  from ALU result r1
- busy  out  1  high in any state other than IDLE

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset values: state IDLE; req_ready 0; rsp_valid 0; rsp_data 0; alu_op, alu_a and alu_b 0; busy 0; round-robin pointer 0 (requester 0 has priority).
- A reset asserted mid-operation aborts the operation. No response is produced and the pending request is lost.
- IDLE:
  - req_ready is combinational and one-hot. It is asserted only to the winning requester with req_valid set.
  - Winner selection: the requester named by the pointer, else the other one.
  - A handshake occurs when req_valid[i] and req_ready[i] are both high.
  - On handshake: latch op/a/b into alu_op, alu_a and alu_b; record owner = i; load the settle counter with SETTLE-1; go to EXEC.
  - The pointer is updated on grant to point at the non-granted requester.
- EXEC:
  - alu_op, alu_a and alu_b are held stable.
  - The counter decrements each cycle. When the counter is 0, capture alu_y into rsp_data, set rsp_valid[owner] and go to RESP.
  - Latency: with SETTLE=1, rsp_valid rises 2 cycles after the accept edge.
- RESP:
  - rsp_valid[owner] and rsp_data are held until rsp_ready[owner] is high.
  - On that edge: clear rsp_valid, go to IDLE.
  - No new request is accepted in the same cycle. Minimum issue interval is SETTLE+2 cycles.
- Simultaneous requests: the pointer decides the winner. The loser keeps req_valid high and is served next, which guarantees no starvation.
- req_ready is 0 in EXEC and RESP. Requester inputs are ignored outside IDLE.
- rsp_ready for the non-owner is ignored. rsp_valid is never high for both bits at once.
- Opcode values are passed through unchanged. The arbiter does not decode operations.

Optional Feature:
- Macro: ALU_ARBITER_STATS_EN.
- When defined, adds outputs grant_cnt0 and grant_cnt1 (16 bits each).
  - Each counter increments on every accepted request of its requester.
  - Counters wrap from 0xFFFF to 0 and reset to 0.
  - Adds output conflict_cnt (16 bits), incremented on every IDLE cycle where both req_valid bits are set and a grant is made.
- When not defined, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg holds:
  - the opcode localparams (OP_AND=0, OP_OR=1, OP_ADD=2, OP_SUB=3, OP_XOR=4)
  - the WIDTH/OPW defaults
  - the FSM state encoding (IDLE=0, EXEC=1, RESP=2)
- One sub-module: rr_pick2. It is a combinational 2-way round-robin picker with inputs valid[1:0] and ptr, and outputs a one-hot grant and a win index.

Test Plan:
- Single request, requester 0 only: op=OP_AND, a=0x00000002, b=0x00000001.
  - Expect req_ready[0] high in the request cycle.
  - Expect rsp_valid[0] 2 cycles after accept, with rsp_data=0x00000000.
  - Expect busy to go high and then drop after rsp_ready.
- Simultaneous requests from reset: req0 AND 0x4,0x6; req1 OR 0x8,0x1.
  - Expect req0 served first with result 0x4.
  - Expect req1 served next with result 0x9.
  - Expect the pointer to then favour req0.
- Both requesters held continuously valid for 6 operations: grants alternate strictly 0,1,0,1,0,1.
- Response backpressure: hold rsp_ready[1]=0 for 5 cycles.
  - Expect rsp_valid[1] and rsp_data held stable.
  - Expect req_ready to stay 0 throughout.
  - Expect completion one cycle after rsp_ready[1] rises.
- Reset asserted in EXEC:
  - Next cycle: all outputs at reset values, no rsp_valid.
  - A subsequent req1 is granted only after req0 if both are valid, since the pointer is back at 0.
- With ALU_ARBITER_STATS_EN: after scenario 3, expect grant_cnt0=3, grant_cnt1=3 and conflict_cnt=6.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, width default and FSM state constants for the ALU arbiter
package alu_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int OPW_DEF   = 3;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu_arbiter_rr_pick2.sv
// rtl/alu_arbiter_rr_pick2.sv - combinational 2-way round-robin picker
//   valid[1:0] : requesters presenting work
//   ptr        : requester holding priority this cycle
//   grant[1:0] : one-hot grant, zero when nobody is valid
//   win        : index of the selected requester (equals ptr when nobody is valid)
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant,
  output logic       win
);

  always_comb begin
    grant = 2'b00;
    win   = ptr;
    if (valid[ptr]) begin
      win        = ptr;
      grant[ptr] = 1'b1;
    end else if (valid[~ptr]) begin
      win         = ~ptr;
      grant[~ptr] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational ALU between two requesters
//   clk, rst (sync, active high)
//   req_valid/req_ready[1:0], req_op/req_a/req_b : per-requester request slices
//   rsp_valid/rsp_ready[1:0], rsp_data           : response to the granted requester
//   alu_op/alu_a/alu_b -> shared ALU, alu_y <- ALU result
//   busy : high outside IDLE
//   Optional macro ALU_ARBITER_STATS_EN adds grant_cnt0, grant_cnt1, conflict_cnt (16 bit)
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int OPW    = OPW_DEF,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*OPW-1:0]   req_op,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic [OPW-1:0]     alu_op,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  input  logic [WIDTH-1:0]   alu_y,
  output logic               busy
`ifdef ALU_ARBITER_STATS_EN
  ,
  output logic [15:0]        grant_cnt0,
  output logic [15:0]        grant_cnt1,
  output logic [15:0]        conflict_cnt
`endif
);

  // Counter holds SETTLE-1 so a value of 0 on entry to EXEC samples after one cycle.
  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  logic [1:0] state;
  logic       ptr;
  logic       owner;
  logic [3:0] settle_cnt;
  logic [1:0] grant;
  logic       win;
  logic       accept;

  rr_pick2 u_pick (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .win   (win)
  );

  assign req_ready = (state == ST_IDLE) ? grant : 2'b00;
  assign accept    = |req_ready;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      ptr        <= 1'b0;
      owner      <= 1'b0;
      settle_cnt <= 4'd0;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_valid  <= 2'b00;
      rsp_data   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            alu_op     <= win ? req_op[OPW +: OPW]     : req_op[0 +: OPW];
            alu_a      <= win ? req_a[WIDTH +: WIDTH]  : req_a[0 +: WIDTH];
            alu_b      <= win ? req_b[WIDTH +: WIDTH]  : req_b[0 +: WIDTH];
            owner      <= win;
            // Hand priority to the requester that was not served.
            ptr        <= ~win;
            settle_cnt <= SETTLE_M1;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (settle_cnt == 4'd0) begin
            rsp_data  <= alu_y;
            rsp_valid <= owner ? 2'b10 : 2'b01;
            state     <= ST_RESP;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready[owner]) begin
            rsp_valid <= 2'b00;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_ARBITER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0   <= 16'd0;
      grant_cnt1   <= 16'd0;
      conflict_cnt <= 16'd0;
    end else if (accept) begin
      if (win) grant_cnt1 <= grant_cnt1 + 16'd1;
      else     grant_cnt0 <= grant_cnt0 + 16'd1;
      if (&req_valid) conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int W  = 32;
  localparam int OW = 3;
  localparam int ST = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [2*OW-1:0] req_op;
  logic [2*W-1:0]  req_a, req_b;
  logic [W-1:0]  rsp_data, alu_a, alu_b, alu_y;
  logic [OW-1:0] alu_op;
  logic          busy;
`ifdef ALU_ARBITER_STATS_EN
  logic [15:0]   grant_cnt0, grant_cnt1, conflict_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W), .OPW(OW), .SETTLE(ST)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_y     (alu_y),
    .busy      (busy)
`ifdef ALU_ARBITER_STATS_EN
    ,
    .grant_cnt0   (grant_cnt0),
    .grant_cnt1   (grant_cnt1),
    .conflict_cnt (conflict_cnt)
`endif
  );

  function automatic logic [W-1:0] alu_ref(input logic [OW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_XOR:  return a ^ b;
      default: return '0;
    endcase
  endfunction

  // The bench plays the shared ALU.
  assign alu_y = alu_ref(alu_op, alu_a, alu_b);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [OW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req_op[i*OW +: OW] = op;
    req_a[i*W +: W]    = a;
    req_b[i*W +: W]    = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    step();
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    int           req;
    logic [OW-1:0] op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  task automatic run_vec(input vec_t v, input int k);
    logic [1:0] oh;
    oh = (v.req == 1) ? 2'b10 : 2'b01;
    set_req(v.req, v.op, v.a, v.b);
    req_valid = oh;
    rsp_ready = 2'b00;
    @(negedge clk);
    chk($sformatf("vec%0d.req_ready", k), req_ready, oh);
    chk($sformatf("vec%0d.busy_idle", k), busy, 1'b0);
    step();
    req_valid = 2'b00;
    @(negedge clk);
    chk($sformatf("vec%0d.busy_exec", k), busy, 1'b1);
    chk($sformatf("vec%0d.rsp_early", k), rsp_valid, 2'b00);
    chk($sformatf("vec%0d.alu_op", k), alu_op, v.op);
    chk($sformatf("vec%0d.alu_a", k), alu_a, v.a);
    chk($sformatf("vec%0d.alu_b", k), alu_b, v.b);
    step();
    @(negedge clk);
    chk($sformatf("vec%0d.rsp_valid", k), rsp_valid, oh);
    chk($sformatf("vec%0d.rsp_data", k), rsp_data, v.exp);
    rsp_ready = oh;
    step();
    rsp_ready = 2'b00;
    @(negedge clk);
    chk($sformatf("vec%0d.rsp_clear", k), rsp_valid, 2'b00);
    chk($sformatf("vec%0d.busy_done", k), busy, 1'b0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int   grants[$];
    // random-phase model state
    bit          pend[2];
    logic [OW-1:0] p_op[2];
    logic [W-1:0]  p_a[2], p_b[2];
    bit          out_act;
    int          out_own, out_acc;
    logic [W-1:0] out_exp;
    int          prio;
    int          m_g0, m_g1, m_cf;

    vecs[0] = '{0, OP_AND, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
    vecs[1] = '{1, OP_OR,  32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F};
    vecs[2] = '{0, OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    vecs[3] = '{1, OP_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
    vecs[4] = '{0, OP_XOR, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5};
    vecs[5] = '{1, OP_ADD, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789};
    vecs[6] = '{1, 3'd7,   32'h0000_0005, 32'h0000_0006, 32'h0000_0000};

    req_op = '0; req_a = '0; req_b = '0;
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    step();
    @(negedge clk);
    chk("reset.req_ready", req_ready, 2'b00);
    chk("reset.rsp_valid", rsp_valid, 2'b00);
    chk("reset.rsp_data", rsp_data, 0);
    chk("reset.alu_op", alu_op, 0);
    chk("reset.alu_a", alu_a, 0);
    chk("reset.alu_b", alu_b, 0);
    chk("reset.busy", busy, 1'b0);
`ifdef ALU_ARBITER_STATS_EN
    chk("reset.grant_cnt0", grant_cnt0, 0);
    chk("reset.grant_cnt1", grant_cnt1, 0);
    chk("reset.conflict_cnt", conflict_cnt, 0);
`endif
    do_reset();

    for (int k = 0; k < 7; k++) run_vec(vecs[k], k);

    // Simultaneous requests from reset: requester 0 first, then 1, then priority back to 0.
    do_reset();
    set_req(0, OP_AND, 32'h4, 32'h6);
    set_req(1, OP_OR,  32'h8, 32'h1);
    req_valid = 2'b11;
    @(negedge clk);
    chk("sim.first_grant", req_ready, 2'b01);
    step();
    req_valid = 2'b10;
    @(negedge clk);
    chk("sim.exec_no_ready", req_ready, 2'b00);
    step();
    @(negedge clk);
    chk("sim.rsp0_valid", rsp_valid, 2'b01);
    chk("sim.rsp0_data", rsp_data, 32'h4);
    chk("sim.resp_no_ready", req_ready, 2'b00);
    step();
    rsp_ready = 2'b10;
    step();
    rsp_ready = 2'b01;
    @(negedge clk);
    chk("sim.nonowner_ignored", rsp_valid, 2'b01);
    step();
    rsp_ready = 2'b00;
    @(negedge clk);
    chk("sim.second_grant", req_ready, 2'b10);
    step();
    req_valid = 2'b00;
    step();
    @(negedge clk);
    chk("sim.rsp1_valid", rsp_valid, 2'b10);
    chk("sim.rsp1_data", rsp_data, 32'h9);
    rsp_ready = 2'b10;
    step();
    rsp_ready = 2'b00;
    req_valid = 2'b11;
    @(negedge clk);
    chk("sim.prio_back_to0", req_ready, 2'b01);
    req_valid = 2'b00;
    step();

    // Both continuously valid: strict alternation over six operations.
    do_reset();
    set_req(0, OP_ADD, 32'h1, 32'h2);
    set_req(1, OP_SUB, 32'h9, 32'h2);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int c = 0; c < 60 && grants.size() < 6; c++) begin
      @(negedge clk);
      if (req_ready == 2'b01) grants.push_back(0);
      else if (req_ready == 2'b10) grants.push_back(1);
      step();
    end
    req_valid = 2'b00;
    chk("alt.count", grants.size(), 6);
    for (int k = 0; k < grants.size(); k++) chk($sformatf("alt.grant%0d", k), grants[k], k % 2);
    for (int c = 0; c < 10 && busy; c++) step();
    chk("alt.idle", busy, 1'b0);
`ifdef ALU_ARBITER_STATS_EN
    chk("alt.grant_cnt0", grant_cnt0, 3);
    chk("alt.grant_cnt1", grant_cnt1, 3);
    chk("alt.conflict_cnt", conflict_cnt, 6);
`endif
    rsp_ready = 2'b00;
    step();

    // Response backpressure on requester 1 while requester 0 waits.
    set_req(1, OP_SUB, 32'd10, 32'd3);
    set_req(0, OP_OR, 32'h10, 32'h01);
    req_valid = 2'b10;
    @(negedge clk);
    chk("bp.grant1", req_ready, 2'b10);
    step();
    req_valid = 2'b01;
    step();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp.hold_valid%0d", c), rsp_valid, 2'b10);
      chk($sformatf("bp.hold_data%0d", c), rsp_data, 32'd7);
      chk($sformatf("bp.hold_ready%0d", c), req_ready, 2'b00);
      step();
    end
    rsp_ready = 2'b10;
    step();
    rsp_ready = 2'b00;
    @(negedge clk);
    chk("bp.done_valid", rsp_valid, 2'b00);
    chk("bp.done_busy", busy, 1'b0);
    chk("bp.next_grant0", req_ready, 2'b01);
    req_valid = 2'b00;
    step();

    // Reset during EXEC aborts the operation and returns priority to requester 0.
    do_reset();
    set_req(0, OP_ADD, 32'h5, 32'h5);
    req_valid = 2'b01;
    @(negedge clk);
    chk("rx.grant0", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rx.rsp_valid", rsp_valid, 2'b00);
    chk("rx.rsp_data", rsp_data, 0);
    chk("rx.alu_op", alu_op, 0);
    chk("rx.alu_a", alu_a, 0);
    chk("rx.alu_b", alu_b, 0);
    chk("rx.busy", busy, 1'b0);
    chk("rx.req_ready", req_ready, 2'b00);
    for (int c = 0; c < 3; c++) begin
      step();
      @(negedge clk);
      chk($sformatf("rx.no_rsp%0d", c), rsp_valid, 2'b00);
    end
    req_valid = 2'b11;
    #1;
    chk("rx.prio0", req_ready, 2'b01);
    req_valid = 2'b00;
    step();

    // Randomised traffic against a transaction-level model.
    do_reset();
    pend[0] = 0; pend[1] = 0;
    out_act = 0; out_own = 0; out_acc = 0; out_exp = '0;
    prio = 0; m_g0 = 0; m_g1 = 0; m_cf = 0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1;
          p_op[i] = OW'($urandom_range(0, 7));
          p_a[i]  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : W'($urandom());
          p_b[i]  = ($urandom_range(0, 7) == 0) ? 32'h0000_0001 : W'($urandom());
          set_req(i, p_op[i], p_a[i], p_b[i]);
        end
      end
      req_valid = {pend[1], pend[0]};
      rsp_ready = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom());
      @(negedge clk);
      if (!out_act) begin
        int         w;
        logic [1:0] exp_rdy;
        w = -1;
        if (pend[prio]) w = prio;
        else if (pend[1-prio]) w = 1 - prio;
        exp_rdy = (w == 0) ? 2'b01 : (w == 1) ? 2'b10 : 2'b00;
        chk("rnd.req_ready", req_ready, exp_rdy);
        chk("rnd.busy_idle", busy, 1'b0);
        chk("rnd.rsp_idle", rsp_valid, 2'b00);
        if (w >= 0) begin
          if (pend[0] && pend[1]) m_cf++;
          if (w == 0) m_g0++; else m_g1++;
          out_act = 1;
          out_own = w;
          out_acc = c;
          out_exp = alu_ref(p_op[w], p_a[w], p_b[w]);
          pend[w] = 0;
          prio = 1 - w;
        end
      end else begin
        chk("rnd.ready_busy", req_ready, 2'b00);
        chk("rnd.busy", busy, 1'b1);
        if (c - out_acc < ST + 1) begin
          chk("rnd.rsp_early", rsp_valid, 2'b00);
        end else begin
          chk("rnd.rsp_valid", rsp_valid, (out_own == 1) ? 2'b10 : 2'b01);
          chk("rnd.rsp_data", rsp_data, out_exp);
          if (rsp_ready[out_own]) out_act = 0;
        end
      end
      step();
    end
`ifdef ALU_ARBITER_STATS_EN
    chk("rnd.grant_cnt0", grant_cnt0, 16'(m_g0));
    chk("rnd.grant_cnt1", grant_cnt1, 16'(m_g1));
    chk("rnd.conflict_cnt", conflict_cnt, 16'(m_cf));
`endif
    chk("rnd.some_grants", (m_g0 > 5) && (m_g1 > 5), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
